reaction_ctrl: RTL
==================

# reaction_ctrl

Sequencing controller for the reaction timer. It derives a 1 ms tick from the system clock and picks a pseudo-random foreperiod. It lights the GO LED when the foreperiod ends, measures the time from GO to the stop button in milliseconds, and presents the result to the display path. It sits between the debounced button logic and the 7-segment display driver, and replaces free-running divided clocks with single-clock tick enables.

## Interface
- CLK_HZ, 100_000_000, system clock frequency
- TICK_HZ, 1000, measurement tick rate; DIV = CLK_HZ/TICK_HZ, which must be an integer ≥ 2
- MIN_DELAY_MS, 1000, fixed part of the foreperiod
- RAND_BITS, 12, width of the random foreperiod addend (0..2^RAND_BITS−1 ms)
- MAX_RT_MS, 9999, reaction-time ceiling (4-digit display)
- clk  in  1  system clock; all logic on rising edge
- rst_n  in  1  asynchronous, active-low reset
- start  in  1  one-cycle pulse from the debouncer: begin a trial
- stop  in  1  one-cycle pulse from the debouncer: subject response
- led_go  out  1  high while the subject must respond
- busy  out  1  high during the WAIT and GO states
- result_ms  out  14  measured reaction time in ms
- result_valid  out  1  result_ms, early and timeout are meaningful
- early  out  1  stop arrived before GO
- timeout  out  1  no stop within MAX_RT_MS

## Operation
- States: IDLE, WAIT, GO, DONE.
- LFSR: 16-bit Galois, polynomial x^16+x^14+x^13+x^11+1, seed 16'hACE1 on reset. It advances every clk cycle regardless of state.
- Tick generator: counts 0..DIV−1 while en=1 and pulses tick for one cycle at DIV−1. It clears to 0 when en=0. en is high in WAIT and GO, and is dropped for one cycle on WAIT→GO so GO starts phase-aligned.
- IDLE → WAIT on start:
  - delay_ms ← MIN_DELAY_MS + lfsr[RAND_BITS−1:0] (value sampled the same cycle);
  - ms counter ← 0;
  - result_valid, early and timeout ← 0.
- WAIT:
  - each tick increments the ms counter;
  - on the tick where counter+1 == delay_ms → GO, counter ← 0;
  - stop → DONE with early=1, result_ms=0.
- GO:
  - each tick increments the counter;
  - stop → DONE with result_ms ← counter (current value, no increment);
  - on the tick where counter+1 == MAX_RT_MS → DONE with result_ms=MAX_RT_MS, timeout=1.
- DONE: result_valid=1; start → WAIT, with the same actions as from IDLE.
- Ignored inputs: start in WAIT/GO; stop in IDLE/DONE.
- Simultaneous events:
  - stop + tick in the same cycle: stop wins, no increment;
  - stop on the WAIT expiry tick → early;
  - start + stop in IDLE/DONE → start wins.
- Counter width is 14 bits and never wraps, because MAX_RT_MS bounds GO and delay_ms ≤ MIN_DELAY_MS + 2^RAND_BITS − 1 < 2^14 (checked at elaboration).

## Timing
- Reset values: state IDLE; led_go, busy, result_valid, early and timeout all 0; result_ms 0; counters 0.
- Outputs are registered or decoded directly from the state register, with no combinational path from inputs.
- start sampled at edge N → busy=1 from N+1. The first tick occurs DIV cycles after WAIT entry.
- WAIT length is exactly delay_ms × DIV cycles + 1 (realignment cycle). led_go rises the cycle the state becomes GO.
- stop sampled at edge N in GO → led_go=0, result_valid=1 and result_ms valid from N+1.
- Results hold through DONE until the next start is accepted.
- Reset mid-trial: everything returns to reset values asynchronously; the LFSR reseeds.

## Structure
- Package rt_pkg holds:
  - state enum (IDLE, WAIT, GO, DONE);
  - LFSR_SEED and LFSR_TAPS constants;
  - the 14-bit ms_t typedef.
- Sub-module ms_tick_gen (parameter DIV; ports clk, rst_n, en, tick). It replaces toggle-style clock dividers and must not generate a derived clock.

## Test plan
Run with CLK_HZ=1000, TICK_HZ=100 (DIV=10), MIN_DELAY_MS=3, RAND_BITS=2, MAX_RT_MS=20. The bench models the LFSR.

1. Reset release, no inputs → all outputs 0 for 200 cycles; LFSR sequence matches the model.
2. Normal trial: start → led_go rises after (3 + lfsr[1:0]) × 10 + 1 cycles. stop 57 cycles after GO → result_ms=5, result_valid=1, early=0.
3. Early: stop 15 cycles into WAIT → DONE, early=1, result_ms=0, led_go never rises.
4. Timeout: no stop → 200 cycles after GO, result_ms=20, timeout=1, led_go=0.
5. Collisions:
   - stop coincident with the 4th GO tick → result_ms=3;
   - stop on the WAIT expiry tick → early=1;
   - start pulses during WAIT/GO are ignored.
6. Reset asserted mid-GO → outputs 0 within the same cycle. A subsequent start from DONE restarts cleanly with result_valid=0.

Source files
------------

// File: rtl/rt_pkg.sv
// Shared types and constants for the reaction-timer sequencing controller.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package rt_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        GO   = 2'd2,
        DONE = 2'd3
    } state_t;

    // Millisecond counter / result width: covers the 4-digit display range.
    typedef logic [13:0] ms_t;

    localparam logic [15:0] LFSR_SEED = 16'hACE1;
    // Right-shifting Galois form of x^16+x^14+x^13+x^11+1:
    // exponent e maps to mask bit e-1.
    localparam logic [15:0] LFSR_TAPS = 16'hB400;

    function automatic logic [15:0] lfsr_advance(input logic [15:0] cur);
        lfsr_advance = cur[0] ? ((cur >> 1) ^ LFSR_TAPS) : (cur >> 1);
    endfunction

endpackage

// File: rtl/ms_tick_gen.sv
// Tick enable generator: one-cycle tick every DIV cycles while en is high.
// Latency: first tick DIV cycles after en rises (counter starts from 0).
// Backpressure: none; dropping en clears the phase so the next run realigns.
// Ports: clk, rst_n (async active-low), en (run/clear), tick (1-cycle pulse).
module ms_tick_gen #(
    parameter int DIV = 10
) (
    input  logic clk,
    input  logic rst_n,
    input  logic en,
    output logic tick
);

    localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [CW-1:0] LAST = CW'(DIV - 1);

    logic [CW-1:0] cnt;

    // Plain enable counter in the clk domain; no divided clock leaves here.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            cnt <= '0;
        end else if (!en || (cnt == LAST)) begin
            cnt <= '0;
        end else begin
            cnt <= cnt + 1'b1;
        end
    end

    assign tick = en && (cnt == LAST);

endmodule

// File: rtl/reaction_ctrl.sv
// Reaction-timer sequencer: random foreperiod, GO LED, ms reaction measurement.
// Latency: start/stop sampled at edge N take effect on outputs from N+1.
// Backpressure: none; start ignored while busy, stop ignored when not busy.
// Ports: clk, rst_n (async active-low), start/stop (1-cycle pulses in);
//        led_go, busy, result_ms, result_valid, early, timeout (out).
module reaction_ctrl
    import rt_pkg::*;
#(
    parameter int CLK_HZ       = 100_000_000,
    parameter int TICK_HZ      = 1000,
    parameter int MIN_DELAY_MS = 1000,
    parameter int RAND_BITS    = 12,
    parameter int MAX_RT_MS    = 9999
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        start,
    input  logic        stop,
    output logic        led_go,
    output logic        busy,
    output logic [13:0] result_ms,
    output logic        result_valid,
    output logic        early,
    output logic        timeout
);

    localparam int  DIV    = CLK_HZ / TICK_HZ;
    localparam ms_t MAX_RT = ms_t'(MAX_RT_MS);

    // Parameter sanity: integer divider of at least 2, and the 14-bit counter
    // can never wrap in either WAIT or GO.
    if ((TICK_HZ <= 0) || (CLK_HZ % TICK_HZ != 0) || (CLK_HZ / TICK_HZ < 2)) begin : g_bad_div
        $error("reaction_ctrl: CLK_HZ/TICK_HZ must be an integer >= 2");
    end
    if ((RAND_BITS < 1) || (RAND_BITS > 13) || (MIN_DELAY_MS < 1) ||
        (MIN_DELAY_MS + (1 << RAND_BITS) - 1 >= (1 << 14))) begin : g_bad_delay
        $error("reaction_ctrl: foreperiod does not fit the 14-bit counter");
    end
    if ((MAX_RT_MS < 1) || (MAX_RT_MS >= (1 << 14))) begin : g_bad_max
        $error("reaction_ctrl: MAX_RT_MS does not fit the 14-bit counter");
    end

    state_t      state;
    logic        realign;   // one extra WAIT cycle with the tick counter held clear
    ms_t         ms_cnt;
    ms_t         delay_ms;
    logic [15:0] lfsr;
    logic        tick;
    logic        tick_en;

    assign tick_en = ((state == WAIT) && !realign) || (state == GO);

    ms_tick_gen #(
        .DIV (DIV)
    ) u_tick (
        .clk   (clk),
        .rst_n (rst_n),
        .en    (tick_en),
        .tick  (tick)
    );

    // Status outputs decode straight from the state register.
    assign led_go       = (state == GO);
    assign busy         = (state == WAIT) || (state == GO);
    assign result_valid = (state == DONE);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            realign   <= 1'b0;
            ms_cnt    <= '0;
            delay_ms  <= '0;
            result_ms <= '0;
            early     <= 1'b0;
            timeout   <= 1'b0;
            lfsr      <= LFSR_SEED;
        end else begin
            // Free-running: the foreperiod depends on when start arrives.
            lfsr <= lfsr_advance(lfsr);

            case (state)
                IDLE, DONE: begin
                    // start beats a simultaneous stop; stop alone is ignored here.
                    if (start) begin
                        state    <= WAIT;
                        realign  <= 1'b0;
                        delay_ms <= ms_t'(MIN_DELAY_MS) + ms_t'(lfsr[RAND_BITS-1:0]);
                        ms_cnt   <= '0;
                        early    <= 1'b0;
                        timeout  <= 1'b0;
                    end
                end

                WAIT: begin
                    // stop has priority over the tick, including the expiry
                    // tick and the realignment cycle: anything before GO is early.
                    if (stop) begin
                        state     <= DONE;
                        early     <= 1'b1;
                        result_ms <= '0;
                        realign   <= 1'b0;
                    end else if (realign) begin
                        state   <= GO;
                        realign <= 1'b0;
                        ms_cnt  <= '0;
                    end else if (tick) begin
                        if ((ms_cnt + 14'd1) == delay_ms) begin
                            realign <= 1'b1;
                            ms_cnt  <= '0;
                        end else begin
                            ms_cnt <= ms_cnt + 14'd1;
                        end
                    end
                end

                GO: begin
                    // A stop coinciding with a tick reports the pre-tick count.
                    if (stop) begin
                        state     <= DONE;
                        result_ms <= ms_cnt;
                    end else if (tick) begin
                        if ((ms_cnt + 14'd1) == MAX_RT) begin
                            state     <= DONE;
                            result_ms <= MAX_RT;
                            timeout   <= 1'b1;
                        end else begin
                            ms_cnt <= ms_cnt + 14'd1;
                        end
                    end
                end

                default: state <= IDLE;
            endcase
        end
    end

endmodule
